// File: rtl/dump_sched_pkg.sv
// Shared types for the dump scheduler: descriptor layout, FSM states and gap length.
package dump_sched_pkg;

  typedef struct packed {
    logic [63:0] ddr_addr;
    logic [31:0] m_len;
    logic [31:0] n_len;
    logic [31:0] sram_addr;
  } dump_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_GAP
  } sched_state_t;

  // Idle cycles between a packer completion and the next launch sequence.
  localparam int GAP_CYCLES = 1;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with flush; storage is an array with a registered read port,
// so the popped descriptor appears on rd_data the cycle after pop.
module desc_fifo
  import dump_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  dump_desc_t                 wr_data,
  input  logic                       pop,
  output dump_desc_t                 rd_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  dump_desc_t    mem [DEPTH];
  dump_desc_t    rd_data_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PW'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dump_scheduler.sv
// Queues tile-dump descriptors and launches axi_master_packer one at a time.
// Optional watchdog on each dump is enabled by defining DUMP_WATCHDOG_EN.
module dump_scheduler
  import dump_sched_pkg::*;
#(
  parameter int DESC_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic [63:0]                   desc_ddr_addr,
  input  logic [31:0]                   desc_m_len,
  input  logic [31:0]                   desc_n_len,
  input  logic [31:0]                   desc_sram_addr,
  input  logic                          abort,
  output logic                          start_dump,
  output logic [63:0]                   reg_ddr_addr,
  output logic [31:0]                   reg_m_len,
  output logic [31:0]                   reg_n_len,
  output logic [31:0]                   reg_addr_d,
  input  logic                          dump_done_irq,
  output logic                          busy,
  output logic [$clog2(DESC_DEPTH):0]   queue_count,
  output logic [CNT_WIDTH-1:0]          done_count,
  output logic [CNT_WIDTH-1:0]          skip_count,
  output logic                          desc_done,
  output logic                          queue_idle_irq,
  output logic                          wdog_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  sched_state_t state_reg, state_next;

  dump_desc_t wr_desc;
  dump_desc_t active;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;

  logic       load_cfg;
  logic       skip_evt;
  logic       done_evt;
  logic       wdog_trip;
  logic       wdog_expired;

  logic                 alive_reg;
  logic [63:0]          reg_ddr_addr_reg;
  logic [31:0]          reg_m_len_reg;
  logic [31:0]          reg_n_len_reg;
  logic [31:0]          reg_addr_d_reg;
  logic [CNT_WIDTH-1:0] done_count_reg;
  logic [CNT_WIDTH-1:0] skip_count_reg;
  logic                 desc_done_reg;
  logic                 queue_idle_reg;
  logic [GW-1:0]        gap_cnt_reg;

  assign wr_desc = '{ddr_addr: desc_ddr_addr, m_len: desc_m_len,
                     n_len: desc_n_len, sram_addr: desc_sram_addr};

  // Abort and a watchdog trip both drop everything still queued, including a same-cycle push.
  assign fifo_flush = abort || wdog_trip;

  desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (desc_valid),
    .wr_data (wr_desc),
    .pop     (fifo_pop),
    .rd_data (active),
    .flush   (fifo_flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (queue_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load_cfg   = 1'b0;
    skip_evt   = 1'b0;
    done_evt   = 1'b0;
    wdog_trip  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !abort) begin
          fifo_pop   = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A zero-row dump would still make the packer write one row, so drop it here.
        if (active.m_len == '0) begin
          skip_evt   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          load_cfg   = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dump_done_irq) begin
          done_evt   = 1'b1;
          state_next = ST_GAP;
        end else if (wdog_expired) begin
          wdog_trip  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_reg        <= 1'b0;
      reg_ddr_addr_reg <= '0;
      reg_m_len_reg    <= '0;
      reg_n_len_reg    <= '0;
      reg_addr_d_reg   <= '0;
      done_count_reg   <= '0;
      skip_count_reg   <= '0;
      desc_done_reg    <= 1'b0;
      queue_idle_reg   <= 1'b0;
      gap_cnt_reg      <= '0;
    end else begin
      alive_reg      <= 1'b1;
      desc_done_reg  <= done_evt;
      queue_idle_reg <= done_evt && (fifo_empty || abort);
      // Config stays put through WAIT_DONE and afterwards: the packer re-reads it per row.
      if (load_cfg) begin
        reg_ddr_addr_reg <= active.ddr_addr;
        reg_m_len_reg    <= active.m_len;
        reg_n_len_reg    <= active.n_len;
        reg_addr_d_reg   <= active.sram_addr;
      end
      if (done_evt) begin
        done_count_reg <= done_count_reg + CNT_WIDTH'(1);
      end
      if (skip_evt) begin
        skip_count_reg <= skip_count_reg + CNT_WIDTH'(1);
      end
      if (state_reg == ST_GAP) begin
        gap_cnt_reg <= gap_cnt_reg + GW'(1);
      end else begin
        gap_cnt_reg <= '0;
      end
    end
  end

`ifdef DUMP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_reg;
  logic          wdog_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_LAUNCH) begin
        wdog_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT_DONE) begin
        wdog_cnt_reg <= wdog_cnt_reg + WW'(1);
      end
      if (wdog_trip) begin
        wdog_err_reg <= 1'b1;
      end
    end
  end

  assign wdog_expired = (wdog_cnt_reg == WDOG_LAST);
  assign wdog_err     = wdog_err_reg;

  logic unused_params;
  assign unused_params = (ADDR_WIDTH > 0);
`else
  assign wdog_expired = 1'b0;
  assign wdog_err     = 1'b0;

  logic unused_params;
  assign unused_params = (ADDR_WIDTH > 0) && (WDOG_CYCLES > 0);
`endif

  assign desc_ready     = alive_reg && !fifo_full;
  assign start_dump     = (state_reg == ST_LAUNCH);
  assign busy           = (state_reg != ST_IDLE) || !fifo_empty;
  assign reg_ddr_addr   = reg_ddr_addr_reg;
  assign reg_m_len      = reg_m_len_reg;
  assign reg_n_len      = reg_n_len_reg;
  assign reg_addr_d     = reg_addr_d_reg;
  assign done_count     = done_count_reg;
  assign skip_count     = skip_count_reg;
  assign desc_done      = desc_done_reg;
  assign queue_idle_irq = queue_idle_reg;

endmodule

// File: tb/tb_dump_scheduler.sv
// Self-checking bench for dump_scheduler: directed scenarios plus randomized queue/drain rounds
// checked against a descriptor-queue reference model and a scripted packer.
module tb_dump_scheduler;

  typedef struct packed {
    logic [63:0] ddr;
    logic [31:0] m;
    logic [31:0] n;
    logic [31:0] s;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_ddr_addr;
  logic [31:0] desc_m_len;
  logic [31:0] desc_n_len;
  logic [31:0] desc_sram_addr;
  logic        abort;
  logic        start_dump;
  logic [63:0] reg_ddr_addr;
  logic [31:0] reg_m_len;
  logic [31:0] reg_n_len;
  logic [31:0] reg_addr_d;
  logic        dump_done_irq;
  logic        busy;
  logic [2:0]  queue_count;
  logic [15:0] done_count;
  logic [15:0] skip_count;
  logic        desc_done;
  logic        queue_idle_irq;
  logic        wdog_err;

  dump_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_ddr_addr  (desc_ddr_addr),
    .desc_m_len     (desc_m_len),
    .desc_n_len     (desc_n_len),
    .desc_sram_addr (desc_sram_addr),
    .abort          (abort),
    .start_dump     (start_dump),
    .reg_ddr_addr   (reg_ddr_addr),
    .reg_m_len      (reg_m_len),
    .reg_n_len      (reg_n_len),
    .reg_addr_d     (reg_addr_d),
    .dump_done_irq  (dump_done_irq),
    .busy           (busy),
    .queue_count    (queue_count),
    .done_count     (done_count),
    .skip_count     (skip_count),
    .desc_done      (desc_done),
    .queue_idle_irq (queue_idle_irq),
    .wdog_err       (wdog_err)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  desc_t pending[$];
  desc_t start_log[$];
  int    start_cyc[$];
  int    seen = 0;
  int    exp_done = 0;
  int    exp_skip = 0;
  int    last_irq_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Packer-side monitor: log the config presented with every launch pulse.
  always @(negedge clk) begin
    if (rst && start_dump) begin
      start_log.push_back('{ddr: reg_ddr_addr, m: reg_m_len, n: reg_n_len, s: reg_addr_d});
      start_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_desc(input desc_t d);
    bit acc;
    desc_valid     = 1'b1;
    desc_ddr_addr  = d.ddr;
    desc_m_len     = d.m;
    desc_n_len     = d.n;
    desc_sram_addr = d.s;
    acc = desc_ready && !abort;
    tick();
    desc_valid = 1'b0;
    if (acc) pending.push_back(d);
  endtask

  function automatic desc_t rand_desc(input bit allow_zero);
    desc_t d;
    d.ddr = {$urandom, $urandom};
    d.m   = (allow_zero && ($urandom_range(0, 3) == 0)) ? 32'd0 : 32'($urandom_range(1, 64));
    d.n   = $urandom;
    d.s   = $urandom;
    return d;
  endfunction

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (start_log.size() > seen) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("start_within_bound", ok, 1'b1);
  endtask

  task automatic pulse_irq();
    dump_done_irq = 1'b1;
    last_irq_cyc  = cyc;
    tick();
    dump_done_irq = 1'b0;
    exp_done++;
    chk("desc_done_pulse", desc_done, 1'b1);
    chk("queue_idle_irq", queue_idle_irq, (pending.size() == 0));
    chk("done_count", done_count, 64'(exp_done));
    tick();
    chk("desc_done_one_cycle", desc_done, 1'b0);
    chk("queue_idle_one_cycle", queue_idle_irq, 1'b0);
  endtask

  // Act as the packer until every queued descriptor is launched or skipped.
  task automatic drain();
    bit    ok;
    bit    have_prev;
    int    nz;
    int    zeros;
    desc_t d;
    desc_t got;
    have_prev = 1'b0;
    while (pending.size() > 0) begin
      nz = 0;
      foreach (pending[i]) if (pending[i].m != 0) nz++;
      if (nz == 0) begin
        repeat (2 * pending.size() + 4) tick();
        exp_skip += pending.size();
        pending.delete();
        break;
      end
      wait_start(ok);
      if (!ok) begin
        pending.delete();
        break;
      end
      zeros = 0;
      while (pending[0].m == 0) begin
        void'(pending.pop_front());
        zeros++;
      end
      exp_skip += zeros;
      d   = pending.pop_front();
      got = start_log[seen];
      chk("reg_ddr_addr", got.ddr, d.ddr);
      chk("reg_m_len", 64'(got.m), 64'(d.m));
      chk("reg_n_len", 64'(got.n), 64'(d.n));
      chk("reg_addr_d", 64'(got.s), 64'(d.s));
      if (have_prev) begin
        // irq -> GAP -> IDLE(pop) -> CHECK -> LAUNCH, plus IDLE+CHECK per skipped entry.
        chk("launch_gap", 64'(start_cyc[seen] - last_irq_cyc), 64'(4 + 2 * zeros));
      end
      seen++;
      chk("start_one_cycle", start_dump, 1'b0);
      chk("qcount_in_dump", 64'(queue_count), 64'(pending.size()));
      chk("skip_at_launch", 64'(skip_count), 64'(exp_skip));
      repeat ($urandom_range(1, 12)) begin
        chk("reg_m_len_hold", 64'(reg_m_len), 64'(d.m));
        tick();
      end
      pulse_irq();
      have_prev = 1'b1;
    end
    repeat (3) tick();
    chk("skip_after_drain", 64'(skip_count), 64'(exp_skip));
    chk("busy_after_drain", busy, 1'b0);
    chk("no_extra_start", 64'(start_log.size()), 64'(seen));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit    ok;
    desc_t d;
    int    st0;
    rst = 1'b0; desc_valid = 1'b0; abort = 1'b0; dump_done_irq = 1'b0;
    desc_ddr_addr = '0; desc_m_len = '0; desc_n_len = '0; desc_sram_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_desc_ready", desc_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start_dump, 1'b0);
    chk("rst_qcount", 64'(queue_count), 64'd0);
    chk("rst_done", 64'(done_count), 64'd0);
    chk("rst_skip", 64'(skip_count), 64'd0);
    chk("rst_wdog", wdog_err, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", desc_ready, 1'b1);

    // Single dump: launch exactly 3 cycles after the push, irq scripted 40 cycles later
    d = '{ddr: 64'h1000, m: 32'd4, n: 32'd16, s: 32'h20};
    push_desc(d);
    chk("single_no_start_c1", start_dump, 1'b0);
    tick();
    chk("single_no_start_c2", start_dump, 1'b0);
    tick();
    chk("single_start_c3", start_dump, 1'b1);
    chk("single_ddr", reg_ddr_addr, 64'h1000);
    chk("single_m", 64'(reg_m_len), 64'd4);
    chk("single_n", 64'(reg_n_len), 64'd16);
    chk("single_sram", 64'(reg_addr_d), 64'h20);
    void'(pending.pop_front());
    repeat (40) begin
      tick();
      chk("single_hold_m", 64'(reg_m_len), 64'd4);
    end
    seen = start_log.size();
    pulse_irq();
    chk("single_regs_retained", 64'(reg_m_len), 64'd4);

    // Completion pulse outside WAIT_DONE is ignored
    dump_done_irq = 1'b1;
    tick();
    dump_done_irq = 1'b0;
    tick();
    chk("stray_irq_done", 64'(done_count), 64'(exp_done));
    chk("stray_irq_pulse", desc_done, 1'b0);

    // Back-to-back: fill the FIFO, a further push is held off
    for (int i = 0; i < 5; i++) push_desc(rand_desc(1'b0));
    chk("full_ready_low", desc_ready, 1'b0);
    push_desc(rand_desc(1'b0));
    chk("full_qcount", 64'(queue_count), 64'd4);
    chk("full_accepted", 64'(pending.size()), 64'd5);
    st0 = seen;
    drain();
    chk("b2b_starts", 64'(seen - st0), 64'd5);

    // Zero length followed by a real dump
    st0 = seen;
    push_desc('{ddr: 64'hABC0, m: 32'd0, n: 32'd8, s: 32'h4});
    push_desc('{ddr: 64'hDEF0, m: 32'd2, n: 32'd8, s: 32'h8});
    drain();
    chk("zero_one_start", 64'(seen - st0), 64'd1);
    chk("zero_last_m", 64'(reg_m_len), 64'd2);

    // Randomized rounds
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 4)) push_desc(rand_desc(1'b1));
      drain();
    end

    // Abort during the first dump's WAIT_DONE; a push in the abort cycle is discarded
    for (int i = 0; i < 3; i++) push_desc(rand_desc(1'b0));
    wait_start(ok);
    if (ok) begin
      d = pending.pop_front();
      seen++;
      chk("abort_qcount_before", 64'(queue_count), 64'(pending.size()));
      abort = 1'b1;
      push_desc(rand_desc(1'b0));
      abort = 1'b0;
      pending.delete();
      chk("abort_qcount_after", 64'(queue_count), 64'd0);
      chk("abort_busy_in_dump", busy, 1'b1);
      chk("abort_regs_held", 64'(reg_m_len), 64'(d.m));
      repeat (3) tick();
      pulse_irq();
      repeat (20) tick();
      chk("abort_no_more_start", 64'(start_log.size()), 64'(seen));
      chk("abort_idle", busy, 1'b0);
    end

    // Asynchronous reset in the middle of a dump
    push_desc(rand_desc(1'b0));
    wait_start(ok);
    repeat (2) tick();
    chk("pre_rst_busy", busy, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_start", start_dump, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", desc_ready, 1'b0);
    chk("midrst_done", 64'(done_count), 64'd0);
    chk("midrst_skip", 64'(skip_count), 64'd0);
    chk("midrst_m_len", 64'(reg_m_len), 64'd0);
    chk("midrst_qcount", 64'(queue_count), 64'd0);
    pending.delete();
    exp_done = 0;
    exp_skip = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_midrst_ready", desc_ready, 1'b1);
    chk("post_midrst_busy", busy, 1'b0);
    seen = start_log.size();

    // Scheduler still works after the reset
    push_desc('{ddr: 64'h55AA, m: 32'd7, n: 32'd3, s: 32'h11});
    drain();
    chk("post_rst_done", 64'(done_count), 64'd1);
    chk("wdog_tied_off", wdog_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
